// File: rtl/wave_capture_buffer_if.sv
// Purpose: sample-in, control, read-port and status bundle for wave_capture_buffer.
// Latency: wires only; the timing is set by the module that uses the slave modport.
// Backpressure: none; samples are qualified by sample_valid and are never stalled.
interface wave_capture_buffer_if #(
    parameter int SAMPLE_W = 10,
    parameter int DEPTH    = 1280,
    parameter int CHANNELS = 2
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    logic [CHANNELS*SAMPLE_W-1:0] sample_in;
    logic                         sample_valid;
    logic                         freeze;
    logic                         rearm;
    logic [SAMPLE_W-1:0]          trig_level;
    logic [CH_W-1:0]              trig_chan;
    logic [11:0]                  rd_col;
    logic [CH_W-1:0]              rd_chan;
    logic [SAMPLE_W-1:0]          rd_high;
    logic [SAMPLE_W-1:0]          rd_low;
    logic [PTR_W-1:0]             wr_ptr;
    logic                         busy;
    logic                         triggered;

    modport master (
        output sample_in, sample_valid, freeze, rearm, trig_level, trig_chan,
        output rd_col, rd_chan,
        input  rd_high, rd_low, wr_ptr, busy, triggered
    );

    modport slave (
        input  sample_in, sample_valid, freeze, rearm, trig_level, trig_chan,
        input  rd_col, rd_chan,
        output rd_high, rd_low, wr_ptr, busy, triggered
    );
endinterface

// File: rtl/wave_capture_buffer.sv
// Purpose: per-channel peak-hold decimation into a circular column buffer with freeze,
//          optional triggered capture (macro WAVE_CAP_TRIGGER_EN) and an envelope read port.
// Latency: column write on the DECIM-th accepted sample; read port 1 cycle, old data on collision.
// Backpressure: none; samples are dropped while clearing, frozen samples are not counted.
module wave_capture_buffer #(
    parameter int SAMPLE_W = 10,
    parameter int DEPTH    = 1280,
    parameter int CHANNELS = 2,
    parameter int DECIM    = 80,
    parameter int OFFSET   = 256
) (
    input  logic                  clk_sample,
    input  logic                  reset,
    wave_capture_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int MEM_N = CHANNELS * DEPTH;
    localparam int AW    = $clog2(MEM_N);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [SAMPLE_W-1:0] OFF_V    = SAMPLE_W'(OFFSET);

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
`ifdef WAVE_CAP_TRIGGER_EN
    localparam int HALF = DEPTH / 2;
    localparam int PC_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PC_W-1:0] POST_LAST = PC_W'(HALF - 1);
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_AFTER_CLEAR = ST_ARMED;
`else
    localparam logic [2:0] ST_AFTER_CLEAR = ST_RUN;
`endif

    logic [2:0]          state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] peak_q [CHANNELS];
    logic [SAMPLE_W-1:0] peak_d [CHANNELS];
    logic [SAMPLE_W-1:0] rd_high_q, rd_high_d;
    logic [SAMPLE_W-1:0] rd_low_q, rd_low_d;

    logic [SAMPLE_W-1:0] mem_q [MEM_N];

    logic                dec_adv;
    logic                col_done;
    logic [SAMPLE_W-1:0] pk_c    [CHANNELS];
    logic [SAMPLE_W-1:0] half_c  [CHANNELS];
    logic [SAMPLE_W-1:0] col_val [CHANNELS];
    logic [AW-1:0]       wr_idx  [CHANNELS];
    logic                mem_we;
    logic                clr_wr;

    logic [AW-1:0]       rd_idx_a, rd_idx_b;
    logic [SAMPLE_W-1:0] rd_va, rd_vb;

`ifdef WAVE_CAP_TRIGGER_EN
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic [PC_W-1:0]     post_cnt_q, post_cnt_d;
    logic [SAMPLE_W-1:0] trig_val;
`else
    logic unused_trig_in;
    assign unused_trig_in = ^{bus.rearm, bus.trig_level, bus.trig_chan};
`endif

    // Peak-hold window: running max per channel, shared sample count, scaled column value.
    always_comb begin
        dec_adv  = bus.sample_valid && !bus.freeze && (state_q != ST_CLEAR);
        col_done = dec_adv && (cnt_q == CNT_LAST);
        cnt_d    = cnt_q;
        if (dec_adv) begin
            cnt_d = col_done ? '0 : cnt_q + 1'b1;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            pk_c[c] = bus.sample_in[c*SAMPLE_W +: SAMPLE_W];
            if (cnt_q != '0 && peak_q[c] > pk_c[c]) begin
                pk_c[c] = peak_q[c];
            end
            peak_d[c]  = dec_adv ? pk_c[c] : peak_q[c];
            half_c[c]  = pk_c[c] >> 1;
            col_val[c] = (half_c[c] < OFF_V) ? '0 : half_c[c] - OFF_V;
            wr_idx[c]  = AW'(c * DEPTH) + AW'(wr_ptr_q);
        end
    end

`ifdef WAVE_CAP_TRIGGER_EN
    // Pick the freshly computed column value of the watched channel.
    always_comb begin
        trig_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(bus.trig_chan) == c) begin
                trig_val = col_val[c];
            end
        end
    end
`endif

    // Mode sequencing: clear sweep, free run, and the optional armed/post/hold capture.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        busy_d   = busy_q;
        mem_we   = 1'b0;
        clr_wr   = 1'b0;
`ifdef WAVE_CAP_TRIGGER_EN
        prev_d     = prev_q;
        post_cnt_d = post_cnt_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                // The first cycle out of reset only raises busy; zeroing starts on the next one.
                busy_d = 1'b1;
                if (busy_q) begin
                    mem_we = 1'b1;
                    clr_wr = 1'b1;
                    if (wr_ptr_q == PTR_LAST) begin
                        wr_ptr_d = '0;
                        busy_d   = 1'b0;
                        state_d  = ST_AFTER_CLEAR;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                mem_we = col_done;
            end
`ifdef WAVE_CAP_TRIGGER_EN
            ST_ARMED: begin
                mem_we = col_done;
                if (col_done && trig_val >= bus.trig_level && prev_q < bus.trig_level) begin
                    state_d    = ST_POST;
                    post_cnt_d = '0;
                end
            end
            ST_POST: begin
                mem_we = col_done;
                if (col_done) begin
                    if (post_cnt_q == POST_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        post_cnt_d = post_cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.rearm) begin
                    state_d = ST_ARMED;
                    prev_d  = '0;
                end
            end
`endif
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        if (mem_we && !clr_wr) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
`ifdef WAVE_CAP_TRIGGER_EN
            prev_d = trig_val;
`endif
        end
    end

    // Envelope of the requested column and its left neighbour; out-of-range reads give 0.
    always_comb begin
        rd_high_d = '0;
        rd_low_d  = '0;
        rd_idx_a  = AW'(bus.rd_chan) * AW'(DEPTH) + AW'(bus.rd_col);
        rd_idx_b  = (bus.rd_col == 12'd0) ? rd_idx_a : rd_idx_a - 1'b1;
        rd_va     = '0;
        rd_vb     = '0;
        if (int'(bus.rd_col) < DEPTH && int'(bus.rd_chan) < CHANNELS) begin
            rd_va     = mem_q[rd_idx_a];
            rd_vb     = mem_q[rd_idx_b];
            rd_high_d = (rd_va > rd_vb) ? rd_va : rd_vb;
            rd_low_d  = (rd_va > rd_vb) ? rd_vb : rd_va;
        end
    end

    // Control and output registers; reset restarts the clear sweep from column 0.
    always_ff @(posedge clk_sample or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            wr_ptr_q  <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rd_high_q <= '0;
            rd_low_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                peak_q[c] <= '0;
            end
`ifdef WAVE_CAP_TRIGGER_EN
            prev_q     <= '0;
            post_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            rd_high_q <= rd_high_d;
            rd_low_q  <= rd_low_d;
            for (int c = 0; c < CHANNELS; c++) begin
                peak_q[c] <= peak_d[c];
            end
`ifdef WAVE_CAP_TRIGGER_EN
            prev_q     <= prev_d;
            post_cnt_q <= post_cnt_d;
`endif
        end
    end

    // Column store: every channel writes the same column in the same cycle.
    always_ff @(posedge clk_sample) begin
        if (mem_we) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mem_q[wr_idx[c]] <= clr_wr ? '0 : col_val[c];
            end
        end
    end

    assign bus.rd_high = rd_high_q;
    assign bus.rd_low  = rd_low_q;
    assign bus.wr_ptr  = wr_ptr_q;
    assign bus.busy    = busy_q;
`ifdef WAVE_CAP_TRIGGER_EN
    assign bus.triggered = (state_q == ST_POST) || (state_q == ST_HOLD);
`else
    assign bus.triggered = 1'b0;
`endif
endmodule

// File: doc/wave_capture_buffer.md
Name: wave_capture_buffer

Overview:
- Parametrised multi-channel successor to the single-trace sample memory in the waveform display path.
- Peak-holds and decimates incoming audio samples per channel, scales and offsets them, and stores them in a circular column buffer.
- Supports freeze and optional triggered capture.
- Serves a registered pixel-column read port that returns the high/low envelope of adjacent columns, so draw blocks can render continuous vertical line segments.

Parameters:
- SAMPLE_W, 10, width of input samples and stored values
- DEPTH, 1280, columns per channel (one per horizontal pixel)
- CHANNELS, 2, independent sample channels
- DECIM, 80, valid input samples per stored column (peak-hold window)
- OFFSET, 256, subtracted after halving; negative results saturate to 0

Ports:
- clk_sample  in  1  sample-domain clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sample_in  in  CHANNELS*SAMPLE_W  packed samples; channel c in bits [c*SAMPLE_W +: SAMPLE_W]
- sample_valid  in  1  qualifies sample_in for all channels this cycle
- freeze  in  1  level; 1 = stop writing, hold buffer contents
- rearm  in  1  one-cycle pulse; leave HOLD and re-arm the trigger
- trig_level  in  SAMPLE_W  trigger threshold on stored (scaled) value
- trig_chan  in  clog2(CHANNELS) (min 1)  channel watched by the trigger
- rd_col  in  12  requested column (VGA horizontal coordinate)
- rd_chan  in  clog2(CHANNELS) (min 1)  requested channel
- rd_high  out  SAMPLE_W  max(mem[rd_col], mem[rd_col-1])
- rd_low  out  SAMPLE_W  min(mem[rd_col], mem[rd_col-1])
- wr_ptr  out  clog2(DEPTH)  next column to write (cursor for draw blocks)
- busy  out  1  1 while in the CLEAR state
- triggered  out  1  1 in POST and HOLD

Behaviour:
- Reset: all outputs 0, decimation count 0, peaks 0, state goes to CLEAR.
- CLEAR:
  - Writes 0 to column wr_ptr of every channel, one column per cycle, with wr_ptr incrementing.
  - After DEPTH cycles, wr_ptr returns to 0, busy drops, and the block enters RUN (ARMED when the trigger is enabled).
  - Input samples are ignored during CLEAR.
- Decimator (per channel):
  - On sample_valid, peak = (count==0) ? sample : max(peak, sample); count wraps at DECIM-1.
  - On the sample_valid cycle where count==DECIM-1, the stored value = (P>>1 < OFFSET) ? 0 : (P>>1) - OFFSET, where P is the peak including the current sample.
  - The value is written at wr_ptr for all channels simultaneously, then wr_ptr advances, wrapping from DEPTH-1 to 0.
- Freeze:
  - While freeze=1, no writes occur and wr_ptr holds. The decimator count and peak also hold.
  - Releasing freeze resumes from the held count.
  - Freeze has no effect in CLEAR.
- RUN (no trigger): free-running writes.
- ARMED:
  - Free-running writes.
  - When the value being stored for trig_chan is ≥ trig_level and the previous stored value for that channel was < trig_level, the block goes to POST. The crossing write itself occurs.
- POST: writes DEPTH/2 further columns, then goes to HOLD.
- HOLD:
  - No writes.
  - rearm moves to ARMED on the next cycle; the previous-value register resets to 0.
  - rearm is ignored in all other states.
- Read port:
  - 1-cycle latency: rd_high/rd_low are registered from rd_col/rd_chan sampled on the previous edge.
  - rd_col==0 returns mem[0] for both outputs.
  - rd_col ≥ DEPTH returns 0 for both outputs.
  - A read and a write to the same column in the same cycle returns the old data.
- Reset mid-operation aborts any state immediately and restarts CLEAR.

Optional Feature:
- Macro: WAVE_CAP_TRIGGER_EN.
- Defined: ARMED/POST/HOLD states as above; triggered and rearm are functional.
- Undefined: RUN only; triggered is tied to 0; rearm and trig_level are ignored; trig_chan is unused.

Test Plan:
- Reset, then DEPTH=1280 cycles -> busy=1 for exactly 1280 cycles; all rd_high/rd_low reads = 0; wr_ptr=0 afterwards.
- Ch0 fed 79 valid samples of 600 plus one of 900 -> column 0 stores (900>>1)-256 = 194; wr_ptr=1.
- Ch1 peak 400 in a window -> stores 0 (saturation); ch0 in the same window stores its own value independently.
- Columns 5=100 and 6=40 stored; rd_col=6 -> one cycle later rd_high=100, rd_low=40. rd_col=1300 -> 0/0.
- freeze=1 for 500 valid samples -> wr_ptr and contents unchanged; after release, the next column stores after the remaining count completes.
- With WAVE_CAP_TRIGGER_EN, trig_level=150: stored sequence 120 then 180 -> triggered=1; exactly 640 further writes occur, then no writes; rearm pulse -> triggered=0, writes resume.
